// File: rtl/mul_div_if.sv
// Request/response bundle between the register-file read/write ports and the
// RV32M multiply/divide execute unit.
interface mul_div_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  // Core side: issues operations and consumes completions.
  modport master (
    output start, op, rs1_data, rs2_data, rd_addr_in,
    input  ready, busy, done, result, rd_addr_out
  );

  // Execute-unit side.
  modport slave (
    input  start, op, rs1_data, rs2_data, rd_addr_in,
    output ready, busy, done, result, rd_addr_out
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M execute unit: one-bit-per-cycle shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up on completion.
// One operation in flight; the core stalls while busy is high.
module mul_div_unit #(
  parameter bit BYPASS_SPECIAL = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  mul_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;          // |A|
  logic [31:0] b_q, b_d;          // |B|
  logic [31:0] hi_q, hi_d;        // product high half / partial remainder
  logic [31:0] lo_q, lo_d;        // multiplier shifting out / quotient shifting in
  logic        sa_q, sa_d;        // A was negative (signed interpretation)
  logic        sb_q, sb_d;        // B was negative (signed interpretation)
  logic        spec_q, spec_d;    // div-by-zero or signed overflow
  logic [31:0] spec_res_q, spec_res_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_addr_out_q, rd_addr_out_d;

  // Accept-side decode
  logic        accept;
  logic        a_signed, b_signed, sa_in, sb_in;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, overflow, special_in;
  logic [31:0] special_val;

  // Iteration datapath
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [31:0] hi_step, lo_step;
  logic [63:0] product, product_fix;
  logic [31:0] quot_fix, rem_fix, calc_res;

  assign bus.ready       = (state_q == IDLE) || (state_q == DONE);
  assign bus.busy        = (state_q == CALC);
  assign bus.done        = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.rd_addr_out = rd_addr_out_q;

  // Operand decode at accept: signedness, magnitudes and RISC-V special cases.
  always_comb begin
    accept      = bus.start && bus.ready;
    // MUL's low word is sign-agnostic, so treating it as signed is harmless.
    a_signed    = (bus.op == 3'b000) || (bus.op == 3'b001) || (bus.op == 3'b010) ||
                  (bus.op == 3'b100) || (bus.op == 3'b110);
    b_signed    = (bus.op == 3'b000) || (bus.op == 3'b001) ||
                  (bus.op == 3'b100) || (bus.op == 3'b110);
    sa_in       = a_signed && bus.rs1_data[31];
    sb_in       = b_signed && bus.rs2_data[31];
    a_mag       = sa_in ? (~bus.rs1_data + 32'd1) : bus.rs1_data;
    b_mag       = sb_in ? (~bus.rs2_data + 32'd1) : bus.rs2_data;
    div_by_zero = bus.op[2] && (bus.rs2_data == 32'd0);
    overflow    = bus.op[2] && !bus.op[0] &&
                  (bus.rs1_data == 32'h8000_0000) && (bus.rs2_data == 32'hFFFF_FFFF);
    special_in  = div_by_zero || overflow;
    special_val = 32'd0;
    if (div_by_zero) begin
      special_val = bus.op[1] ? bus.rs1_data : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_val = bus.op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One multiply or divide iteration, plus sign fix-up of the final step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : 32'd0)};
    div_shift = {hi_q, lo_q[31]};
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q[2]) begin
      // Remainder stays below |B| after every step, so 32 bits suffice.
      if (!div_diff[32]) begin
        hi_step = div_diff[31:0];
        lo_step = {lo_q[30:0], 1'b1};
      end else begin
        hi_step = div_shift[31:0];
        lo_step = {lo_q[30:0], 1'b0};
      end
    end else begin
      hi_step = mul_sum[32:1];
      lo_step = {mul_sum[0], lo_q[31:1]};
    end
    product     = {hi_step, lo_step};
    product_fix = (sa_q ^ sb_q) ? (~product + 64'd1) : product;
    quot_fix    = (sa_q ^ sb_q) ? (~lo_step + 32'd1) : lo_step;
    rem_fix     = sa_q ? (~hi_step + 32'd1) : hi_step;
    if (op_q[2]) begin
      calc_res = op_q[1] ? rem_fix : quot_fix;
    end else begin
      calc_res = (op_q[1:0] == 2'b00) ? product_fix[31:0] : product_fix[63:32];
    end
  end

  // Next-state and datapath-register updates.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    sa_d          = sa_q;
    sb_d          = sb_q;
    spec_d        = spec_q;
    spec_res_d    = spec_res_q;
    rd_d          = rd_q;
    result_d      = result_q;
    rd_addr_out_d = rd_addr_out_q;
    case (state_q)
      CALC: begin
        hi_d    = hi_step;
        lo_d    = lo_step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d       = DONE;
          result_d      = spec_q ? spec_res_q : calc_res;
          rd_addr_out_d = rd_q;
        end
      end
      default: begin  // IDLE and DONE both accept
        if (state_q == DONE) state_d = IDLE;
        if (accept) begin
          op_d       = bus.op;
          a_d        = a_mag;
          b_d        = b_mag;
          hi_d       = 32'd0;
          lo_d       = bus.op[2] ? a_mag : b_mag;
          sa_d       = sa_in;
          sb_d       = sb_in;
          spec_d     = special_in;
          spec_res_d = special_val;
          rd_d       = bus.rd_addr_in;
          count_d    = 5'd0;
          if (BYPASS_SPECIAL && special_in) begin
            state_d       = DONE;
            result_d      = special_val;
            rd_addr_out_d = bus.rd_addr_in;
          end else begin
            state_d = CALC;
          end
        end
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= 5'd0;
      op_q          <= 3'd0;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      sa_q          <= 1'b0;
      sb_q          <= 1'b0;
      spec_q        <= 1'b0;
      spec_res_q    <= 32'd0;
      rd_q          <= 5'd0;
      result_q      <= 32'd0;
      rd_addr_out_q <= 5'd0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      sa_q          <= sa_d;
      sb_q          <= sb_d;
      spec_q        <= spec_d;
      spec_res_q    <= spec_res_d;
      rd_q          <= rd_d;
      result_q      <= result_d;
      rd_addr_out_q <= rd_addr_out_d;
    end
  end

endmodule
